// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: state encoding and width constants.
package div_pkg;

    localparam int DIV_WIDTH      = 32;
    localparam int DIV_ITERATIONS = DIV_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } divState_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the
// divisor and keep the difference only when it does not borrow.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   remIn,
    input  logic             dvdBit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   remOut,
    output logic             qBit
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;
    logic           unusedRemMsb_s;

    // The partial remainder stays below the divisor, so its top bit is always clear.
    assign unusedRemMsb_s = remIn[WIDTH];

    // Borrow out of the trial subtract is the "remainder < divisor" decision.
    always_comb begin
        shifted_s = {remIn[WIDTH-1:0], dvdBit};
        trial_s   = shifted_s - {1'b0, divisor};
        if (trial_s[WIDTH] == 1'b0) begin
            remOut = trial_s;
            qBit   = 1'b1;
        end else begin
            remOut = shifted_s;
            qBit   = 1'b0;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed restoring divider: one quotient bit per cycle on magnitudes,
// sign fix-up in a final cycle, one-cycle ready pulse on completion.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    divState_t      state_r;
    divState_t      nextState_s;
    logic [CW-1:0]  count_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH:0]   rem_r;
    logic             sA_r;
    logic             sB_r;
    logic             div0_r;
    logic [WIDTH:0]   stepRem_s;
    logic             stepQ_s;
    logic             lastStep_s;
    logic [WIDTH-1:0] fixResult_s;
    logic [WIDTH-1:0] fixRem_s;

    // Two's-complement magnitude; the most negative value maps onto itself as unsigned.
    function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    div_step #(.WIDTH(WIDTH)) uStep (
        .remIn   (rem_r),
        .dvdBit  (dvd_r[WIDTH-1]),
        .divisor (dvs_r),
        .remOut  (stepRem_s),
        .qBit    (stepQ_s)
    );

    // Next-state decode; a new start always wins and restarts the iteration.
    always_comb begin
        nextState_s = state_r;
        lastStep_s  = (count_r == CW'(WIDTH - 1));
        case (state_r)
            IDLE: begin
                if (ctrl_div) nextState_s = ITER;
                else          nextState_s = IDLE;
            end
            ITER: begin
                if (ctrl_div)        nextState_s = ITER;
                else if (lastStep_s) nextState_s = DONE;
                else                 nextState_s = ITER;
            end
            DONE: begin
                if (ctrl_div) nextState_s = ITER;
                else          nextState_s = IDLE;
            end
            default: nextState_s = IDLE;
        endcase
    end

    // Sign fix-up of the magnitude results; divide-by-zero forces a zero quotient.
    always_comb begin
        fixRem_s = sA_r ? -rem_r[WIDTH-1:0] : rem_r[WIDTH-1:0];
        if (div0_r) begin
            fixResult_s = {WIDTH{1'b0}};
        end else begin
            fixResult_s = (sA_r ^ sB_r) ? -quo_r : quo_r;
        end
    end

    // State register and busy flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            busy    <= 1'b0;
        end else begin
            state_r <= nextState_s;
            busy    <= (nextState_s != IDLE);
        end
    end

    // Operand capture, iteration datapath and registered result outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r        <= {CW{1'b0}};
            dvd_r          <= {WIDTH{1'b0}};
            dvs_r          <= {WIDTH{1'b0}};
            quo_r          <= {WIDTH{1'b0}};
            rem_r          <= {(WIDTH + 1){1'b0}};
            sA_r           <= 1'b0;
            sB_r           <= 1'b0;
            div0_r         <= 1'b0;
            data_result    <= {WIDTH{1'b0}};
            data_remainder <= {WIDTH{1'b0}};
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            if (ctrl_div) begin
                dvd_r   <= absVal(data_operandA);
                dvs_r   <= absVal(data_operandB);
                sA_r    <= data_operandA[WIDTH-1];
                sB_r    <= data_operandB[WIDTH-1];
                div0_r  <= (data_operandB == {WIDTH{1'b0}});
                rem_r   <= {(WIDTH + 1){1'b0}};
                quo_r   <= {WIDTH{1'b0}};
                count_r <= {CW{1'b0}};
            end else if (state_r == ITER) begin
                rem_r   <= stepRem_s;
                dvd_r   <= {dvd_r[WIDTH-2:0], 1'b0};
                quo_r   <= {quo_r[WIDTH-2:0], stepQ_s};
                count_r <= count_r + CW'(1);
            end
            // An abort arriving in the fix-up cycle suppresses the completion.
            if ((state_r == DONE) && !ctrl_div) begin
                data_result    <= fixResult_s;
                data_remainder <= fixRem_s;
                data_exception <= div0_r;
                data_resultRDY <= 1'b1;
            end else begin
                data_resultRDY <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model with per-cycle
// compare, directed boundary cases and randomized operands with aborts.
module tb_seq_divider;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clock;
    logic         reset;
    logic         ctrl_div;
    logic [W-1:0] data_operandA;
    logic [W-1:0] data_operandB;
    logic [W-1:0] data_result;
    logic [W-1:0] data_remainder;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_div       (ctrl_div),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check32(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference arithmetic in 64 bits: truncating division, remainder follows dividend.
    function automatic logic [W-1:0] refQuot(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'h0) return 32'h0;
        return W'(sa / sb);
    endfunction

    function automatic logic [W-1:0] refRem(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'h0) return a;
        return W'(sa % sb);
    endfunction

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return W'($urandom_range(0, 200));
            4:       return -W'($urandom_range(1, 200));
            default: return W'($urandom);
        endcase
    endfunction

    // Behavioural model: a start arms a countdown; completion LAT edges later.
    int           remaining  = 0;
    logic         modelValid = 1'b0;
    logic         expRdy     = 1'b0;
    logic         expBusy    = 1'b0;
    logic         expExc     = 1'b0;
    logic         pendExc    = 1'b0;
    logic [W-1:0] expRes     = 32'h0;
    logic [W-1:0] expRem     = 32'h0;
    logic [W-1:0] pendRes    = 32'h0;
    logic [W-1:0] pendRem    = 32'h0;

    always @(posedge clock) begin
        modelValid <= 1'b1;
        expRdy     <= 1'b0;
        if (reset) begin
            remaining <= 0;
            expBusy   <= 1'b0;
            expRes    <= 32'h0;
            expRem    <= 32'h0;
            expExc    <= 1'b0;
        end else if (ctrl_div) begin
            remaining <= LAT;
            expBusy   <= 1'b1;
            pendRes   <= refQuot(data_operandA, data_operandB);
            pendRem   <= refRem(data_operandA, data_operandB);
            pendExc   <= (data_operandB == 32'h0);
        end else if (remaining > 0) begin
            remaining <= remaining - 1;
            if (remaining == 1) begin
                expRdy  <= 1'b1;
                expBusy <= 1'b0;
                expRes  <= pendRes;
                expRem  <= pendRem;
                expExc  <= pendExc;
            end
        end
    end

    always @(negedge clock) begin
        if (modelValid) begin
            check1("cyc ready", data_resultRDY, expRdy);
            check1("cyc busy", busy, expBusy);
            check1("cyc exception", data_exception, expExc);
            check32("cyc result", data_result, expRes);
            check32("cyc remainder", data_remainder, expRem);
        end
    end

    task automatic startOp(input logic [W-1:0] a, input logic [W-1:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_div      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_div      = 1'b0;
        data_operandA = W'($urandom);
        data_operandB = W'($urandom);
    endtask

    task automatic waitReady(output int edges);
        edges = 0;
        while (edges < LAT + 8) begin
            @(posedge clock);
            #1;
            edges++;
            if (data_resultRDY) break;
        end
    endtask

    logic [W-1:0] dirA [9] = '{32'd100, 32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C, 32'h80000000,
                               32'h80000000, 32'd7, 32'd55, 32'h80000000};
    logic [W-1:0] dirB [9] = '{32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd1,
                               32'hFFFFFFFF, 32'd100, 32'd0, 32'd0};
    logic [W-1:0] dirQ [9] = '{32'd14, 32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14, 32'h80000000,
                               32'h80000000, 32'd0, 32'd0, 32'd0};
    logic [W-1:0] dirR [9] = '{32'd2, 32'hFFFFFFFE, 32'd2, 32'hFFFFFFFE, 32'd0,
                               32'd0, 32'd7, 32'd55, 32'h80000000};
    logic         dirE [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int   edges;
        logic sawRdy;
        reset         = 1'b1;
        ctrl_div      = 1'b0;
        data_operandA = 32'h0;
        data_operandB = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        check32("reset result", data_result, 32'h0);
        check32("reset remainder", data_remainder, 32'h0);
        check1("reset ready", data_resultRDY, 1'b0);
        check1("reset busy", busy, 1'b0);
        reset = 1'b0;

        check32("model q -100/7", refQuot(32'hFFFFFF9C, 32'd7), 32'hFFFFFFF2);
        check32("model r -100/7", refRem(32'hFFFFFF9C, 32'd7), 32'hFFFFFFFE);
        check32("model q ovf", refQuot(32'h80000000, 32'hFFFFFFFF), 32'h80000000);
        check32("model r 55/0", refRem(32'd55, 32'd0), 32'd55);

        for (int i = 0; i < 9; i++) begin
            startOp(dirA[i], dirB[i]);
            waitReady(edges);
            check32($sformatf("dir%0d latency", i), edges, LAT);
            check32($sformatf("dir%0d result", i), data_result, dirQ[i]);
            check32($sformatf("dir%0d remainder", i), data_remainder, dirR[i]);
            check1($sformatf("dir%0d exception", i), data_exception, dirE[i]);
            @(posedge clock);
            #1;
            check1($sformatf("dir%0d ready drop", i), data_resultRDY, 1'b0);
        end

        startOp(32'd1000, 32'd3);
        sawRdy = 1'b0;
        repeat (9) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) sawRdy = 1'b1;
        end
        startOp(32'd81, 32'd9);
        waitReady(edges);
        check1("abort no ready", sawRdy, 1'b0);
        check32("abort latency", edges, LAT);
        check32("abort result", data_result, 32'd9);
        check32("abort remainder", data_remainder, 32'd0);

        startOp(32'd1000, 32'd3);
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check1("midreset busy", busy, 1'b0);
        check32("midreset result", data_result, 32'h0);
        check32("midreset remainder", data_remainder, 32'h0);
        check1("midreset ready", data_resultRDY, 1'b0);
        ctrl_div      = 1'b1;
        data_operandA = 32'd50;
        data_operandB = 32'd5;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        ctrl_div = 1'b0;
        check1("reset+start busy", busy, 1'b0);
        sawRdy = 1'b0;
        repeat (LAT + 3) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) sawRdy = 1'b1;
        end
        check1("reset no ready", sawRdy, 1'b0);
        startOp(32'd1000, 32'd3);
        waitReady(edges);
        check32("post-reset latency", edges, LAT);
        check32("post-reset result", data_result, 32'd333);
        check32("post-reset remainder", data_remainder, 32'd1);

        for (int n = 0; n < 30; n++) begin
            startOp(pickOperand(), pickOperand());
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(0, LAT)) @(posedge clock);
                #1;
                startOp(pickOperand(), pickOperand());
            end
            waitReady(edges);
            check32($sformatf("rand%0d latency", n), edges, LAT);
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
        end

        repeat (2) @(posedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
